// File: rtl/nvram_upload_if.sv
// Bundle of HPS ioctl, RAM read port and save-control signals for nvram_upload.
// The slave modport is the nvram_upload side; master is the surrounding system.
interface nvram_upload_if #(
    parameter int AW = 16
);
    logic          ioctl_upload;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_index;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          ioctl_upload_req;
    logic [AW-1:0] ram_addr;
    logic          ram_req;
    logic          ram_ack;
    logic [7:0]    ram_data;
    logic          cpu_wr;
    logic          save_req;
    logic          err;

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index,
        output ram_ack, ram_data, cpu_wr, save_req,
        input  ioctl_din, ioctl_wait, ioctl_upload_req, ram_addr, ram_req, err
    );

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index,
        input  ram_ack, ram_data, cpu_wr, save_req,
        output ioctl_din, ioctl_wait, ioctl_upload_req, ram_addr, ram_req, err
    );
endinterface

// File: rtl/nvram_upload.sv
// nvram_upload: serves NVRAM bytes to the HPS during an ioctl upload session and
// requests an upload when dirty data is saved. Optional macro: NVRAM_UPLOAD_TIMEOUT_EN.
module nvram_upload #(
    parameter logic [7:0]  INDEX = 8'd4,
    parameter int          AW    = 16,
    parameter logic [16:0] SIZE  = 17'd1024,
    parameter int          TMO   = 255
) (
    input  logic          clk_sys,
    input  logic          RESET_n,
    nvram_upload_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e        state_r, state_s;
    logic [7:0]    din_r, din_s;
    logic          wait_r, wait_s;
    logic          ram_req_r, ram_req_s;
    logic [AW-1:0] ram_addr_r, ram_addr_s;
    logic          err_r, err_s;
    logic          upload_req_r, upload_req_s;
    logic          dirty_r, dirty_s;
    logic          save_d_r;
    logic          upload_d_r;

    logic          selected_s;
    logic          start_s;
    logic          save_rise_s;
    logic          in_range_s;
    logic          tmo_hit_s;

    assign selected_s  = bus.ioctl_upload && (bus.ioctl_index == INDEX);
    assign start_s     = selected_s && !upload_d_r;
    assign save_rise_s = bus.save_req && !save_d_r;
    assign in_range_s  = (bus.ioctl_addr < {8'd0, SIZE});

`ifdef NVRAM_UPLOAD_TIMEOUT_EN
    localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    logic [CW-1:0] tmo_cnt_r;

    assign tmo_hit_s = (tmo_cnt_r == CW'(TMO - 1));

    // Cycles spent waiting for ram_ack; cleared whenever the FSM is idle.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            tmo_cnt_r <= {CW{1'b0}};
        end else if (state_r == ST_REQ) begin
            tmo_cnt_r <= tmo_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= {CW{1'b0}};
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Read FSM next state and next output values.
    always_comb begin
        state_s    = state_r;
        din_s      = din_r;
        wait_s     = wait_r;
        ram_req_s  = ram_req_r;
        ram_addr_s = ram_addr_r;
        err_s      = err_r;
        case (state_r)
            ST_IDLE: begin
                if (selected_s && bus.ioctl_rd) begin
                    if (in_range_s) begin
                        state_s    = ST_REQ;
                        wait_s     = 1'b1;
                        ram_req_s  = 1'b1;
                        ram_addr_s = bus.ioctl_addr[AW-1:0];
                    end else begin
                        din_s = 8'hFF;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Session loss wins over a same-cycle ack: the byte has no reader.
                if (!bus.ioctl_upload) begin
                    state_s   = ST_IDLE;
                    wait_s    = 1'b0;
                    ram_req_s = 1'b0;
                end else if (bus.ram_ack) begin
                    state_s   = ST_IDLE;
                    din_s     = bus.ram_data;
                    wait_s    = 1'b0;
                    ram_req_s = 1'b0;
                end else if (tmo_hit_s) begin
                    state_s   = ST_IDLE;
                    din_s     = 8'h00;
                    wait_s    = 1'b0;
                    ram_req_s = 1'b0;
                    err_s     = 1'b1;
                end else begin
                    state_s = ST_REQ;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                wait_s    = 1'b0;
                ram_req_s = 1'b0;
            end
        endcase
    end

    // Dirty tracking and upload request; a CPU write always re-dirties.
    always_comb begin
        dirty_s      = dirty_r;
        upload_req_s = upload_req_r;
        if (start_s) begin
            upload_req_s = 1'b0;
            dirty_s      = 1'b0;
        end else if (save_rise_s && dirty_r) begin
            upload_req_s = 1'b1;
        end else begin
            upload_req_s = upload_req_r;
        end
        if (bus.cpu_wr) begin
            dirty_s = 1'b1;
        end else begin
            dirty_s = dirty_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r      <= ST_IDLE;
            din_r        <= 8'h00;
            wait_r       <= 1'b0;
            ram_req_r    <= 1'b0;
            ram_addr_r   <= {AW{1'b0}};
            err_r        <= 1'b0;
            upload_req_r <= 1'b0;
            dirty_r      <= 1'b0;
            save_d_r     <= 1'b0;
            upload_d_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            din_r        <= din_s;
            wait_r       <= wait_s;
            ram_req_r    <= ram_req_s;
            ram_addr_r   <= ram_addr_s;
            err_r        <= err_s;
            upload_req_r <= upload_req_s;
            dirty_r      <= dirty_s;
            save_d_r     <= bus.save_req;
            upload_d_r   <= bus.ioctl_upload;
        end
    end

    assign bus.ioctl_din        = din_r;
    assign bus.ioctl_wait       = wait_r;
    assign bus.ram_req          = ram_req_r;
    assign bus.ram_addr         = ram_addr_r;
    assign bus.err              = err_r;
    assign bus.ioctl_upload_req = upload_req_r;

endmodule

// File: tb/tb_nvram_upload.sv
// Randomized self-checking bench for nvram_upload against a transaction-level
// model: a byte array for RAM contents plus dirty/request flags.
module tb_nvram_upload;
    localparam logic [7:0]  INDEX = 8'd4;
    localparam int          AW    = 16;
    localparam logic [16:0] SIZE  = 17'd1024;
    localparam int          TMO   = 8;

    logic clk_sys = 1'b0;
    logic RESET_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem [0:1023];
    logic [7:0] exp_din;
    logic       exp_dirty;
    logic       exp_req;

    nvram_upload_if #(.AW(AW)) bus ();

    nvram_upload #(
        .INDEX(INDEX),
        .AW(AW),
        .SIZE(SIZE),
        .TMO(TMO)
    ) dut (
        .clk_sys(clk_sys),
        .RESET_n(RESET_n),
        .bus(bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One selected read; lat = ack-low cycles after the read edge.
    task automatic do_read(input logic [24:0] addr, input int lat, input bit poke_rd);
        int wait_hi;
        logic [7:0] data;
        bus.ioctl_addr = addr;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        if (addr < 25'(SIZE)) begin
            data    = mem[addr[9:0]];
            wait_hi = 0;
            check("ram_req_up", 32'(bus.ram_req), 32'd1);
            check("ram_addr", 32'(bus.ram_addr), 32'(addr[AW-1:0]));
            for (int i = 0; i < lat; i++) begin
                if (bus.ioctl_wait) wait_hi++;
                if (poke_rd) begin
                    bus.ioctl_rd   = 1'b1;
                    bus.ioctl_addr = 25'($urandom_range(0, 1023));
                end
                bus.ram_data = 8'($urandom);
                tick();
                bus.ioctl_rd = 1'b0;
            end
            if (bus.ioctl_wait) wait_hi++;
            check("din_hold", 32'(bus.ioctl_din), 32'(exp_din));
            check("ram_addr_hold", 32'(bus.ram_addr), 32'(addr[AW-1:0]));
            bus.ram_ack  = 1'b1;
            bus.ram_data = data;
            tick();
            bus.ram_ack  = 1'b0;
            exp_din      = data;
            check("wait_cycles", 32'(wait_hi), 32'(lat + 1));
            check("wait_done", 32'(bus.ioctl_wait), 32'd0);
            check("ram_req_done", 32'(bus.ram_req), 32'd0);
            check("din_data", 32'(bus.ioctl_din), 32'(exp_din));
        end else begin
            exp_din = 8'hFF;
            check("oor_din", 32'(bus.ioctl_din), 32'hFF);
            check("oor_wait", 32'(bus.ioctl_wait), 32'd0);
            check("oor_ram_req", 32'(bus.ram_req), 32'd0);
        end
    endtask

    task automatic upload_restart(input logic [7:0] idx);
        bus.ioctl_upload = 1'b0;
        tick();
        bus.ioctl_index  = idx;
        bus.ioctl_upload = 1'b1;
        tick();
        if (idx == INDEX) begin
            exp_req   = 1'b0;
            exp_dirty = 1'b0;
        end
        bus.ioctl_index = INDEX;
    endtask

    task automatic save_toggle();
        if (!bus.save_req) begin
            bus.save_req = 1'b1;
            tick();
            if (exp_dirty) exp_req = 1'b1;
        end else begin
            bus.save_req = 1'b0;
            tick();
        end
    endtask

    task automatic cpu_write();
        bus.cpu_wr = 1'b1;
        tick();
        bus.cpu_wr = 1'b0;
        exp_dirty  = 1'b1;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[16] = 8'h5A;
        RESET_n          = 1'b0;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = 25'd0;
        bus.ioctl_index  = INDEX;
        bus.ram_ack      = 1'b0;
        bus.ram_data     = 8'h00;
        bus.cpu_wr       = 1'b0;
        bus.save_req     = 1'b0;
        exp_din = 8'h00; exp_dirty = 1'b0; exp_req = 1'b0;
        #1;
        check("rst_din", 32'(bus.ioctl_din), 32'h00);
        check("rst_wait", 32'(bus.ioctl_wait), 32'd0);
        check("rst_ram_req", 32'(bus.ram_req), 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_upload_req", 32'(bus.ioctl_upload_req), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        tick(); tick();
        RESET_n = 1'b1;
        bus.ioctl_upload = 1'b1;
        tick();

        // Directed reads: nominal, boundary, first out-of-range.
        do_read(25'h010, 3, 1'b0);
        do_read(25'h3FF, 0, 1'b0);
        do_read(25'h400, 0, 1'b0);
        do_read(25'h000, 1, 1'b1);

        // Randomized reads, including non-selected ones.
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            if (kind == 0) begin
                bus.ioctl_index = 8'($urandom_range(5, 255));
                bus.ioctl_addr  = 25'($urandom_range(0, 1023));
                bus.ioctl_rd    = 1'b1;
                tick();
                bus.ioctl_rd    = 1'b0;
                bus.ioctl_index = INDEX;
                check("unsel_wait", 32'(bus.ioctl_wait), 32'd0);
                check("unsel_din", 32'(bus.ioctl_din), 32'(exp_din));
            end else if (kind == 1) begin
                do_read(25'($urandom_range(1024, 33554431)), 0, 1'b0);
            end else begin
                do_read(25'($urandom_range(0, 1023)), int'($urandom_range(0, 5)), 1'($urandom));
            end
        end

        // Abort two cycles into REQ, then a late ack must be ignored.
        bus.ioctl_addr = 25'h005;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        tick();
        check("abort_pre_wait", 32'(bus.ioctl_wait), 32'd1);
        bus.ioctl_upload = 1'b0;
        tick();
        check("abort_wait", 32'(bus.ioctl_wait), 32'd0);
        check("abort_ram_req", 32'(bus.ram_req), 32'd0);
        bus.ram_ack  = 1'b1;
        bus.ram_data = ~exp_din;
        tick();
        bus.ram_ack = 1'b0;
        check("abort_din", 32'(bus.ioctl_din), 32'(exp_din));
        bus.ioctl_upload = 1'b1;
        tick();
        exp_dirty = 1'b0; exp_req = 1'b0;

        // Dirty/save/upload-request sequence.
        cpu_write();
        save_toggle();
        check("save_req_set", 32'(bus.ioctl_upload_req), 32'(exp_req));
        tick();
        check("save_req_hold", 32'(bus.ioctl_upload_req), 32'd1);
        save_toggle();
        upload_restart(INDEX);
        check("start_clears", 32'(bus.ioctl_upload_req), 32'd0);
        save_toggle();
        check("clean_save", 32'(bus.ioctl_upload_req), 32'd0);
        save_toggle();
        bus.ioctl_upload = 1'b0;
        tick();
        bus.ioctl_upload = 1'b1;
        bus.cpu_wr       = 1'b1;
        tick();
        bus.cpu_wr = 1'b0;
        exp_dirty  = 1'b1;
        exp_req    = 1'b0;
        save_toggle();
        check("wr_at_start", 32'(bus.ioctl_upload_req), 32'd1);
        save_toggle();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: cpu_write();
                1: save_toggle();
                default: upload_restart(($urandom_range(0, 1) == 0) ? INDEX : 8'd5);
            endcase
            check("rand_upload_req", 32'(bus.ioctl_upload_req), 32'(exp_req));
        end
        bus.save_req = 1'b0;
        tick();

        // Stalled RAM: timeout or indefinite wait depending on build.
        bus.ioctl_addr = 25'h007;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        cnt = 0;
`ifdef NVRAM_UPLOAD_TIMEOUT_EN
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            if (bus.ioctl_wait) cnt++;
        end
        check("tmo_wait_hi", 32'(cnt), 32'(TMO - 1));
        tick();
        exp_din = 8'h00;
        check("tmo_wait", 32'(bus.ioctl_wait), 32'd0);
        check("tmo_err", 32'(bus.err), 32'd1);
        check("tmo_din", 32'(bus.ioctl_din), 32'h00);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.ioctl_wait) cnt++;
        end
        check("stall_wait_hi", 32'(cnt), 32'd100);
        check("stall_err", 32'(bus.err), 32'd0);
        bus.ram_ack  = 1'b1;
        bus.ram_data = mem[7];
        tick();
        bus.ram_ack = 1'b0;
        exp_din     = mem[7];
        check("stall_din", 32'(bus.ioctl_din), 32'(exp_din));
`endif

        // Asynchronous reset in the middle of a pending read.
        cpu_write();
        save_toggle();
        check("pre_rst_req", 32'(bus.ioctl_upload_req), 32'd1);
        bus.save_req = 1'b0;
        bus.ioctl_addr = 25'h009;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        check("pre_rst_wait", 32'(bus.ioctl_wait), 32'd1);
        #2;
        RESET_n = 1'b0;
        #1;
        check("arst_ram_req", 32'(bus.ram_req), 32'd0);
        check("arst_wait", 32'(bus.ioctl_wait), 32'd0);
        check("arst_upload_req", 32'(bus.ioctl_upload_req), 32'd0);
        check("arst_err", 32'(bus.err), 32'd0);
        check("arst_din", 32'(bus.ioctl_din), 32'h00);
        tick();
        RESET_n = 1'b1;
        bus.ram_ack  = 1'b1;
        bus.ram_data = 8'hA5;
        tick();
        bus.ram_ack = 1'b0;
        check("post_rst_ram_req", 32'(bus.ram_req), 32'd0);
        check("post_rst_din", 32'(bus.ioctl_din), 32'h00);
        save_toggle();
        check("post_rst_clean", 32'(bus.ioctl_upload_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nvram_upload.md
NVRAM_UPLOAD -- requirements
Module: nvram_upload

Interface
REQ-001 SHALL have parameter INDEX, default 8'd4: ioctl_index value served by this block.
REQ-002 SHALL have parameter AW, default 16: RAM address width.
REQ-003 SHALL have parameter SIZE, default 17'd1024: number of served bytes.
REQ-004 SHALL have parameter TMO, default 255: ack timeout in clk_sys cycles (see Configuration).
REQ-005 SHALL have port clk_sys  in  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port RESET_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port ioctl_upload  in  1  HPS upload session active.
REQ-008 SHALL have port ioctl_rd  in  1  one-cycle byte read strobe from HPS.
REQ-009 SHALL have port ioctl_addr  in  25  byte address of the read.
REQ-010 SHALL have port ioctl_index  in  8  session target index.
REQ-011 SHALL have port ioctl_din  out  8  byte returned to HPS.
REQ-012 SHALL have port ioctl_wait  out  1  HPS stall while a byte is pending.
REQ-013 SHALL have port ioctl_upload_req  out  1  request to the HPS to start an upload.
REQ-014 SHALL have port ram_addr  out  AW  RAM read address.
REQ-015 SHALL have port ram_req  out  1  RAM read request, level.
REQ-016 SHALL have port ram_ack  in  1  one-cycle grant; ram_data valid in the same cycle.
REQ-017 SHALL have port ram_data  in  8  RAM read data.
REQ-018 SHALL have port cpu_wr  in  1  CPU write strobe into the served RAM.
REQ-019 SHALL have port save_req  in  1  save trigger, level, for example OSD autosave.
REQ-020 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-021 SHALL serve only when ioctl_upload=1 and ioctl_index==INDEX ("selected"); ioctl_rd when not selected is ignored.
REQ-022 SHALL implement FSM IDLE -> REQ -> IDLE.
REQ-023 IDLE + selected ioctl_rd with ioctl_addr<SIZE: next cycle ioctl_wait=1, ram_req=1, ram_addr=ioctl_addr[AW-1:0], state REQ.
REQ-024 IDLE + selected ioctl_rd with ioctl_addr>=SIZE: next cycle ioctl_din=8'hFF, ioctl_wait stays 0, ram_req stays 0.
REQ-025 REQ + ram_ack: same edge latch ram_data into ioctl_din; next cycle ram_req=0, ioctl_wait=0, state IDLE. Minimum latency from rd to wait low is 2 cycles.
REQ-026 ioctl_rd arriving in REQ SHALL be ignored; ioctl_din SHALL only change on completion.
REQ-027 ioctl_upload falling in REQ SHALL abort: next cycle IDLE, ram_req=0, ioctl_wait=0, ioctl_din unchanged.
REQ-028 Dirty flag SHALL set on any cpu_wr; cpu_wr and upload start in the same cycle leave dirty set.
REQ-029 On a save_req rising edge with dirty=1, ioctl_upload_req SHALL go 1 next cycle and hold.
REQ-030 ioctl_upload_req SHALL clear, and dirty SHALL clear, on the cycle a selected ioctl_upload rises.
REQ-031 save_req rising with dirty=0 SHALL have no effect.

Reset
REQ-032 While RESET_n=0: state IDLE; ioctl_din=8'h00; ioctl_wait, ram_req, ioctl_upload_req, err, dirty=0; ram_addr=0; save_req edge detector=0.
REQ-033 Reset mid-REQ SHALL drop ram_req and ioctl_wait asynchronously, with no pending access retained.

Configuration
REQ-034 Macro NVRAM_UPLOAD_TIMEOUT_EN: when defined, a counter runs in REQ. If no ram_ack arrives after TMO cycles: ioctl_din=8'h00, err=1 (sticky until reset), state IDLE, ioctl_wait=0. When undefined, REQ waits indefinitely and err is tied 0.

Verification
REQ-035 INDEX=4, SIZE=1024: selected rd addr 0x010, ram_ack 3 cycles later with data 0x5A -> wait high 4 cycles, ioctl_din=0x5A, wait low, ram_addr=0x010.
REQ-036 Selected rd addr 0x400 -> ioctl_din=0xFF next cycle, wait never high, ram_req never high.
REQ-037 cpu_wr pulse, then save_req rise -> ioctl_upload_req=1 next cycle; ioctl_upload rises with index 4 -> req and dirty clear same cycle; second save_req rise -> no req.
REQ-038 ioctl_upload drops 2 cycles into REQ -> next cycle wait=0, ram_req=0, a late ram_ack ignored, ioctl_din unchanged.
REQ-039 TIMEOUT_EN, TMO=8, no ram_ack -> after 8 cycles ioctl_din=0x00, err=1, wait=0; without the macro, wait stays 1 for 100 cycles.
REQ-040 RESET_n low during REQ -> ram_req, wait, upload_req, err go 0 without a clock edge; ioctl_din=0x00.
